mult_sweep_checker: RTL and testbench
=====================================

Name: mult_sweep_checker

Overview:
- Synthesizable exhaustive stimulus generator and error checker for the team's multiplier interface: operand outputs in1/in2, result inputs {overflow,out}.
- Drives every operand pair into a multiplier under test (e.g. an approximate Dadda instance) and compares each result against the exact product.
- Accumulates error metrics: error count, max absolute error, sum of absolute error, first failing pair.
- Used for on-chip BIST and as the stimulus side in simulation.

Parameters:
WIDTH, 6, operand width in bits; vector count N = 2^(2*WIDTH)
LAT, 0, DUT latency in clock cycles from operands to result (0 = combinational DUT)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a sweep
in1  output  WIDTH  operand A to DUT
in2  output  WIDTH  operand B to DUT
out  input  2*WIDTH-1  DUT product low bits
overflow  input  1  DUT product MSB; DUT result R = {overflow,out}
busy  output  1  sweep or drain in progress
done  output  1  one-cycle pulse at sweep completion
err_count  output  2*WIDTH+1  number of vectors with R != exact
max_abs_err  output  2*WIDTH  largest |exact - R|
sum_abs_err  output  4*WIDTH  sum of |exact - R| over all vectors
first_err_valid  output  1  set once the first mismatch is recorded
first_err_a  output  WIDTH  in1 of first mismatching vector
first_err_b  output  WIDTH  in2 of first mismatching vector

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including in1, in2, busy, done, all metrics and first_err_*.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE: start=1 -> SWEEP on the next edge; that same edge clears all metrics and first_err_*, and loads vector index k=0. Metrics otherwise hold their last values in IDLE.
- SWEEP: in1 = k[2*WIDTH-1:WIDTH], in2 = k[WIDTH-1:0], driven from registers. Index k increments every cycle, so in2 is the inner loop.
  - After the cycle presenting k = N-1: go to DRAIN if LAT>0, else DONE.
  - in1/in2 hold their last values after the sweep ends.
- Expected product and the operand pair are carried through a LAT-deep delay line with a valid bit. The DUT result for vector k is sampled in the cycle k+LAT after the vector is presented; metrics update on that cycle's closing edge.
- DRAIN: lasts exactly LAT cycles, so the last result is checked, then DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 in SWEEP and DRAIN only. Total busy cycles = N + LAT (4096 for defaults).
- start is ignored while busy=1 or done=1.
- Arithmetic:
  - exact = in1*in2, unsigned, 2*WIDTH bits.
  - abs_err = exact>=R ? exact-R : R-exact, 2*WIDTH bits.
  - Mismatch iff abs_err != 0.
  - err_count +1 on mismatch; it cannot wrap (maximum N fits in 2*WIDTH+1 bits).
  - max_abs_err updates when abs_err > max_abs_err.
  - sum_abs_err adds abs_err; it cannot overflow at 4*WIDTH bits.
- first_err_*: captured on the first mismatch only. first_err_valid then holds at 1 until the next start or reset.
- Reset asserted mid-sweep: immediate return to IDLE with all outputs 0; the partial sweep is discarded. A fresh start is required.
- X/Z on out/overflow outside the sampling cycles has no effect.

Test Plan:
- Exact behavioural multiplier, LAT=0, start pulse -> busy high for 4096 cycles, then done pulse. err_count=0, max_abs_err=0, sum_abs_err=0, first_err_valid=0.
- DUT with product bit0 forced 0 -> err_count=1024 (both operands odd), max_abs_err=1, sum_abs_err=1024, first_err_a=1, first_err_b=1.
- DUT with overflow tied 0 -> first_err_a=33, first_err_b=63 (first product >= 2048 = 2079), max_abs_err=2048.
- LAT=2, exact model with 2 register stages -> err_count=0, busy high for 4098 cycles, done exactly once.
- start re-pulsed at cycle 100 of a sweep -> ignored: sweep completes at cycle 4096, and metrics match a single uninterrupted run.
- rst_n low at cycle 2000, released, new start -> all outputs 0 during reset; second sweep metrics identical to a clean run.

Source files
------------

// File: rtl/mult_sweep_checker.sv
// Exhaustive operand sweep and error checker for a WIDTH x WIDTH multiplier under test.
// Presents every {in1,in2} pair once and accumulates error metrics against the exact product.
module mult_sweep_checker #(
    parameter int WIDTH = 6,
    parameter int LAT   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     in1,
    output logic [WIDTH-1:0]     in2,
    input  logic [2*WIDTH-2:0]   out,
    input  logic                 overflow,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     err_count,
    output logic [2*WIDTH-1:0]   max_abs_err,
    output logic [4*WIDTH-1:0]   sum_abs_err,
    output logic                 first_err_valid,
    output logic [WIDTH-1:0]     first_err_a,
    output logic [WIDTH-1:0]     first_err_b
);

    localparam int PW = 2 * WIDTH;
    localparam int DW = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'((LAT > 0) ? (LAT - 1) : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    state;
    logic [DW-1:0] drain_cnt;
    logic [PW-1:0] exact_now;
    logic          vec_valid;
    logic          sweep_start;

    logic          chk_valid;
    logic [PW-1:0] chk_exact;
    logic [WIDTH-1:0] chk_a;
    logic [WIDTH-1:0] chk_b;
    logic [PW-1:0] result;
    logic [PW-1:0] abs_err;

    assign sweep_start = (state == ST_IDLE) && start;
    assign vec_valid   = (state == ST_SWEEP);
    assign busy        = (state == ST_SWEEP) || (state == ST_DRAIN);
    assign done        = (state == ST_DONE);
    assign exact_now   = PW'(in1) * PW'(in2);
    assign result      = {overflow, out};

    // The operand registers double as the vector index k = {in1,in2}, so in2 is the inner loop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in1       <= '0;
            in2       <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SWEEP;
                        {in1, in2} <= '0;
                        drain_cnt <= '0;
                    end
                end
                ST_SWEEP: begin
                    if ({in1, in2} == {PW{1'b1}}) begin
                        state     <= (LAT > 0) ? ST_DRAIN : ST_DONE;
                        drain_cnt <= '0;
                    end else begin
                        {in1, in2} <= {in1, in2} + PW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Expected product and operands travel alongside the DUT latency so the check lines up.
    generate
        if (LAT == 0) begin : g_comb
            assign chk_valid = vec_valid;
            assign chk_exact = exact_now;
            assign chk_a     = in1;
            assign chk_b     = in2;
        end else begin : g_pipe
            logic [LAT-1:0]   pipe_valid;
            logic [PW-1:0]    pipe_exact [LAT];
            logic [WIDTH-1:0] pipe_a     [LAT];
            logic [WIDTH-1:0] pipe_b     [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_valid <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        pipe_exact[i] <= '0;
                        pipe_a[i]     <= '0;
                        pipe_b[i]     <= '0;
                    end
                end else begin
                    pipe_valid[0] <= vec_valid;
                    pipe_exact[0] <= exact_now;
                    pipe_a[0]     <= in1;
                    pipe_b[0]     <= in2;
                    for (int i = 1; i < LAT; i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                        pipe_exact[i] <= pipe_exact[i-1];
                        pipe_a[i]     <= pipe_a[i-1];
                        pipe_b[i]     <= pipe_b[i-1];
                    end
                end
            end

            assign chk_valid = pipe_valid[LAT-1];
            assign chk_exact = pipe_exact[LAT-1];
            assign chk_a     = pipe_a[LAT-1];
            assign chk_b     = pipe_b[LAT-1];
        end
    endgenerate

    always_comb begin
        abs_err = '0;
        if (chk_exact >= result) begin
            abs_err = chk_exact - result;
        end else begin
            abs_err = result - chk_exact;
        end
    end

    // Result bits are only looked at when chk_valid is set, so undriven DUT outputs elsewhere are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count       <= '0;
            max_abs_err     <= '0;
            sum_abs_err     <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
        end else if (sweep_start) begin
            err_count       <= '0;
            max_abs_err     <= '0;
            sum_abs_err     <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
        end else if (chk_valid && (abs_err != '0)) begin
            err_count   <= err_count + (PW+1)'(1);
            sum_abs_err <= sum_abs_err + (4*WIDTH)'(abs_err);
            if (abs_err > max_abs_err) begin
                max_abs_err <= abs_err;
            end
            if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_a     <= chk_a;
                first_err_b     <= chk_b;
            end
        end
    end

endmodule

// File: tb/tb_mult_sweep_checker.sv
// Bench for mult_sweep_checker: a LAT=0 instance against faulty multiplier models
// and a LAT=2 instance against a two-stage exact multiplier.
module tb_mult_sweep_checker;

    localparam int W  = 6;
    localparam int PW = 2 * W;

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start2;
    int   mode;

    logic [W-1:0]    in1_0, in2_0, fa_0, fb_0;
    logic [PW-2:0]   out_0;
    logic            ovf_0, busy_0, done_0, fv_0;
    logic [PW:0]     ec_0;
    logic [PW-1:0]   me_0;
    logic [4*W-1:0]  se_0;
    logic [PW-1:0]   prod_0;

    logic [W-1:0]    in1_2, in2_2, fa_2, fb_2;
    logic            busy_2, done_2, fv_2;
    logic [PW:0]     ec_2;
    logic [PW-1:0]   me_2;
    logic [4*W-1:0]  se_2;
    logic [PW-1:0]   p1_2, p2_2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_sweep_checker #(.WIDTH(W), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .in1(in1_0), .in2(in2_0), .out(out_0), .overflow(ovf_0),
        .busy(busy_0), .done(done_0), .err_count(ec_0), .max_abs_err(me_0),
        .sum_abs_err(se_0), .first_err_valid(fv_0), .first_err_a(fa_0), .first_err_b(fb_0)
    );

    mult_sweep_checker #(.WIDTH(W), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .in1(in1_2), .in2(in2_2), .out(p2_2[PW-2:0]), .overflow(p2_2[PW-1]),
        .busy(busy_2), .done(done_2), .err_count(ec_2), .max_abs_err(me_2),
        .sum_abs_err(se_2), .first_err_valid(fv_2), .first_err_a(fa_2), .first_err_b(fb_2)
    );

    // Multiplier models: 0 exact, 1 bit0 stuck 0, 2 overflow tied 0, 3 all zero, 4 off by +1
    always_comb begin
        prod_0 = PW'(in1_0) * PW'(in2_0);
        case (mode)
            1: prod_0 = prod_0 & ~PW'(1);
            2: prod_0 = prod_0 & {1'b0, {(PW-1){1'b1}}};
            3: prod_0 = '0;
            4: prod_0 = prod_0 + PW'(1);
            default: ;
        endcase
    end
    assign out_0 = prod_0[PW-2:0];
    assign ovf_0 = prod_0[PW-1];

    always @(posedge clk) begin
        p1_2 <= PW'(in1_2) * PW'(in2_2);
        p2_2 <= p1_2;
    end

    task automatic check_output(input string name, input longint actual, input longint expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Pulses start on the chosen instance and watches a bounded window of cycles.
    task automatic apply_stimulus(input bit sel, input int repulse_at,
                                  output int busy_cycles, output int done_pulses);
        busy_cycles = 0;
        done_pulses = 0;
        @(negedge clk);
        if (sel) start2 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start2 = 1'b0;
        for (int i = 0; i < 4120; i++) begin
            if (i == repulse_at) begin
                if (sel) start2 = 1'b1; else start0 = 1'b1;
            end else begin
                start0 = 1'b0;
                start2 = 1'b0;
            end
            if (sel ? busy_2 : busy_0) busy_cycles++;
            if (sel ? done_2 : done_0) done_pulses++;
            @(negedge clk);
        end
        start0 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic check_metrics(input string tag, input longint e_err, input longint e_max,
                                 input longint e_sum, input longint e_fv,
                                 input longint e_fa, input longint e_fb);
        check_output({tag, ".err_count"}, ec_0, e_err);
        check_output({tag, ".max_abs_err"}, me_0, e_max);
        check_output({tag, ".sum_abs_err"}, se_0, e_sum);
        check_output({tag, ".first_err_valid"}, fv_0, e_fv);
        if (e_fv != 0) begin
            check_output({tag, ".first_err_a"}, fa_0, e_fa);
            check_output({tag, ".first_err_b"}, fb_0, e_fb);
        end
    endtask

    typedef struct {
        int mode;
        int err;
        int maxe;
        int sum;
        int fv;
        int fa;
        int fb;
    } vec_t;

    vec_t vecs[5];
    int   bc, dc, ovf_cnt;

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start2 = 1'b0;
        mode   = 0;

        ovf_cnt = 0;
        for (int a = 0; a < 64; a++)
            for (int b = 0; b < 64; b++)
                if (a * b >= 2048) ovf_cnt++;

        vecs[0] = '{mode:1, err:1024, maxe:1,    sum:1024,         fv:1, fa:1,  fb:1};
        vecs[1] = '{mode:0, err:0,    maxe:0,    sum:0,            fv:0, fa:0,  fb:0};
        vecs[2] = '{mode:2, err:ovf_cnt, maxe:2048, sum:ovf_cnt*2048, fv:1, fa:33, fb:63};
        vecs[3] = '{mode:3, err:3969, maxe:3969, sum:2016*2016,    fv:1, fa:1,  fb:1};
        vecs[4] = '{mode:4, err:4096, maxe:1,    sum:4096,         fv:1, fa:0,  fb:0};

        #1;
        check_output("reset.busy", busy_0, 0);
        check_output("reset.done", done_0, 0);
        check_output("reset.in1", in1_0, 0);
        check_output("reset.in2", in2_0, 0);
        check_metrics("reset", 0, 0, 0, 0, 0, 0);
        check_output("reset.first_err_a", fa_0, 0);
        check_output("reset.first_err_b", fb_0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode;
            apply_stimulus(1'b0, -1, bc, dc);
            check_output($sformatf("v%0d.busy_cycles", i), bc, 4096);
            check_output($sformatf("v%0d.done_pulses", i), dc, 1);
            check_metrics($sformatf("v%0d", i), vecs[i].err, vecs[i].maxe, vecs[i].sum,
                          vecs[i].fv, vecs[i].fa, vecs[i].fb);
        end
        check_output("hold.in1", in1_0, 63);
        check_output("hold.in2", in2_0, 63);

        apply_stimulus(1'b1, -1, bc, dc);
        check_output("lat2.busy_cycles", bc, 4098);
        check_output("lat2.done_pulses", dc, 1);
        check_output("lat2.err_count", ec_2, 0);
        check_output("lat2.max_abs_err", me_2, 0);
        check_output("lat2.sum_abs_err", se_2, 0);
        check_output("lat2.first_err_valid", fv_2, 0);

        mode = 1;
        apply_stimulus(1'b0, 100, bc, dc);
        check_output("repulse.busy_cycles", bc, 4096);
        check_output("repulse.done_pulses", dc, 1);
        check_metrics("repulse", 1024, 1, 1024, 1, 1, 1);

        mode = 3;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (2000) @(negedge clk);
        check_output("midsweep.busy", busy_0, 1);
        rst_n = 1'b0;
        #1;
        check_output("rst.busy", busy_0, 0);
        check_output("rst.done", done_0, 0);
        check_output("rst.in1", in1_0, 0);
        check_output("rst.in2", in2_0, 0);
        check_metrics("rst", 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_output("rst.held_busy", busy_0, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_output("rst.idle_busy", busy_0, 0);
        mode = 1;
        apply_stimulus(1'b0, -1, bc, dc);
        check_output("after_rst.busy_cycles", bc, 4096);
        check_output("after_rst.done_pulses", dc, 1);
        check_metrics("after_rst", 1024, 1, 1024, 1, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
